// File: rtl/trigger_multi.sv
// trigger_multi: multi-stage nibble-LUT stream trigger; TRIGGER_MULTI_DELAY_EN adds per-stage post-match delay
module trigger_multi #(
  parameter int DW = 32,
  parameter int NS = 4,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] cfg_stage,
  input  logic          wr_mask,
  input  logic          wr_value,
  input  logic          wr_config,
  input  logic          wr_delay,
  input  logic [DW-1:0] cfg_data,
  input  logic          arm,
  input  logic          sti_tvalid,
  input  logic          sti_tready,
  input  logic [DW-1:0] sti_tdata,
  output logic          lut_busy,
  output logic          cfg_err,
  output logic          capture,
  output logic          run,
  output logic [3:0]    level
);
  localparam int NN = DW / 4;
  typedef enum logic [1:0] {IDLE, ARMED, DELAY, FIRED} state_t;
  state_t state, nxt;
  logic [DW-1:0] mask_r [NS];
  logic [DW-1:0] value_r [NS];
  logic [20:0] cfg_r [NS];
  logic [15:0] tbl [NS][NN];
  logic [16:0] occ [NS];
  logic [DW-1:0] cur_mask, ld_mask, ld_val;
  logic [SW-1:0] ld_stage;
  logic [3:0] ld_addr;
  logic arm_d, xfer, start_any, dly_done;
  logic [NS-1:0] hit, act, mt, ms, ml;
  logic [15:0] sel_dly;
  assign xfer = sti_tvalid & sti_tready;
  assign start_any = |ms;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        mask_r[s] <= '0;
        value_r[s] <= '0;
        cfg_r[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (cfg_stage == SW'(s)) begin
          if (wr_mask && !lut_busy) mask_r[s] <= cfg_data;
          if (wr_value && !lut_busy) value_r[s] <= cfg_data;
          if (wr_config) cfg_r[s] <= cfg_data[20:0];
        end
      end
    end
  end
  always_comb begin
    cur_mask = '0;
    ld_val = '0;
    for (int s = 0; s < NS; s++) begin
      if (cfg_stage == SW'(s)) cur_mask = mask_r[s];
      if (ld_stage == SW'(s)) ld_val = value_r[s];
    end
  end
  // The mask is latched at wr_value; the value register is frozen while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_busy <= 1'b0;
      ld_addr <= '0;
      ld_stage <= '0;
      ld_mask <= '0;
    end else if (lut_busy) begin
      ld_addr <= ld_addr + 1'b1;
      if (ld_addr == 4'hf) lut_busy <= 1'b0;
    end else if (wr_value) begin
      lut_busy <= 1'b1;
      ld_addr <= '0;
      ld_stage <= cfg_stage;
      ld_mask <= cur_mask;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++)
        for (int k = 0; k < NN; k++) tbl[s][k] <= '1;
    end else if (lut_busy) begin
      for (int s = 0; s < NS; s++)
        for (int k = 0; k < NN; k++)
          if (ld_stage == SW'(s))
            tbl[s][k][ld_addr] <= ~|((ld_addr ^ ld_val[4*k +: 4]) & ld_mask[4*k +: 4]);
    end
  end
  always_comb begin
    hit = '1;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NN; k++) hit[s] = hit[s] & tbl[s][k][sti_tdata[4*k +: 4]];
  end
  always_comb begin
    act = '0;
    mt = '0;
    ms = '0;
    ml = '0;
    for (int s = 0; s < NS; s++) begin
      act[s] = state == ARMED && cfg_r[s][19:16] == level;
      mt[s] = act[s] & hit[s] & xfer & (occ[s] == {1'b0, cfg_r[s][15:0]});
      ms[s] = mt[s] & cfg_r[s][20];
      ml[s] = mt[s] & ~cfg_r[s][20];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_d <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      arm_d <= arm;
      if (lut_busy && (wr_value || wr_mask)) cfg_err <= 1'b1;
      else if (arm && !arm_d) cfg_err <= 1'b0;
    end
  end
`ifdef TRIGGER_MULTI_DELAY_EN
  logic [15:0] dly [NS];
  logic [15:0] dcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) dly[s] <= '0;
    end else if (wr_delay) begin
      for (int s = 0; s < NS; s++)
        if (cfg_stage == SW'(s)) dly[s] <= cfg_data[15:0];
    end
  end
  // Lowest-numbered start stage wins when several match together
  always_comb begin
    sel_dly = '0;
    for (int s = NS - 1; s >= 0; s--)
      if (ms[s]) sel_dly = dly[s];
  end
  always_ff @(posedge clk) begin
    if (rst) dcnt <= '0;
    else if (state == ARMED) dcnt <= sel_dly;
    else if (state == DELAY && xfer) dcnt <= dcnt - 1'b1;
  end
  assign dly_done = xfer && dcnt == 16'd1;
`else
  logic unused;
  assign unused = wr_delay;
  assign sel_dly = '0;
  assign dly_done = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = arm && !lut_busy ? ARMED : IDLE;
      ARMED:   nxt = start_any ? (sel_dly == '0 ? FIRED : DELAY) : ARMED;
      DELAY:   nxt = dly_done ? FIRED : DELAY;
      default: nxt = FIRED;
    endcase
    if (!arm) nxt = IDLE;
  end
  always_comb begin
    capture = state != IDLE;
    run = state == FIRED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int s = 0; s < NS; s++) occ[s] <= '0;
    end else if (state == IDLE && nxt == ARMED) begin
      level <= '0;
      for (int s = 0; s < NS; s++) occ[s] <= '0;
    end else if (state == ARMED) begin
      for (int s = 0; s < NS; s++)
        if (act[s] & hit[s] & xfer) occ[s] <= occ[s] + 1'b1;
      if (!start_any && |ml && level != 4'(NS - 1)) level <= level + 1'b1;
    end
  end
endmodule

// File: tb/tb_trigger_multi.sv
// tb_trigger_multi: directed scoreboard bench for trigger_multi
module tb_trigger_multi;
  localparam int DW = 32, NS = 4, SW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] cfg_stage = '0;
  logic wr_mask = 0, wr_value = 0, wr_config = 0, wr_delay = 0;
  logic [DW-1:0] cfg_data = '0;
  logic arm = 0, sti_tvalid = 0, sti_tready = 0;
  logic [DW-1:0] sti_tdata = '0;
  logic lut_busy, cfg_err, capture, run;
  logic [3:0] level;
  typedef struct {
    string nm;
    logic [7:0] v;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0;
  trigger_multi #(.DW(DW), .NS(NS), .SW(SW)) dut (
    .clk(clk), .rst(rst), .cfg_stage(cfg_stage), .wr_mask(wr_mask), .wr_value(wr_value),
    .wr_config(wr_config), .wr_delay(wr_delay), .cfg_data(cfg_data), .arm(arm),
    .sti_tvalid(sti_tvalid), .sti_tready(sti_tready), .sti_tdata(sti_tdata),
    .lut_busy(lut_busy), .cfg_err(cfg_err), .capture(capture), .run(run), .level(level)
  );
  always #5 clk = ~clk;
  // Monitor: compares {run,capture,level,lut_busy,cfg_err} against each queued expectation
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_chk++;
      if ({run, capture, level, lut_busy, cfg_err} === mon_e.v) n_pass++;
      else $display("FAIL %s: got run/cap/lvl/busy/err=%b expected %b", mon_e.nm,
                    {run, capture, level, lut_busy, cfg_err}, mon_e.v);
    end
  end
  task automatic ex(string nm, int r, int c, int l, int b, int e);
    exp_t t;
    t.nm = nm;
    t.v = {1'(r), 1'(c), 4'(l), 1'(b), 1'(e)};
    q.push_back(t);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(int kind, int st, logic [31:0] d);
    cfg_stage = SW'(st);
    cfg_data = d;
    wr_mask = kind == 0;
    wr_value = kind == 1;
    wr_config = kind == 2;
    wr_delay = kind == 3;
    cyc();
    {wr_mask, wr_value, wr_config, wr_delay} = '0;
  endtask
  task automatic load(int st, logic [31:0] d);
    wr(1, st, d);
    repeat (16) cyc();
  endtask
  task automatic send(logic [31:0] d, logic rdy);
    sti_tvalid = 1'b1;
    sti_tready = rdy;
    sti_tdata = d;
    cyc();
    sti_tvalid = 1'b0;
    sti_tready = 1'b0;
  endtask
  task automatic set_arm(logic a);
    arm = a;
    cyc();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) cyc();
    ex("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int s = 1; s < NS; s++) wr(2, s, 32'h000F_0000);
    wr(0, 0, 32'h0000_00FF);
    wr(1, 0, 32'h0000_0042);
    ex("busy_start", 0, 0, 0, 1, 0);
    repeat (16) cyc();
    ex("busy_end", 0, 0, 0, 0, 0);
    wr(2, 0, 32'h0010_0000);
    set_arm(1'b1);
    ex("arm_a", 0, 1, 0, 0, 0);
    send(32'h1234_5643, 1'b1);
    ex("nomatch_43", 0, 1, 0, 0, 0);
    send(32'h1234_5642, 1'b1);
    ex("fire_42", 1, 1, 0, 0, 0);
    set_arm(1'b0);
    ex("disarm_a", 0, 0, 0, 0, 0);
    wr(0, 1, 32'h0000_00FF);
    load(1, 32'h0000_0077);
    wr(2, 1, 32'h0011_0000);
    wr(2, 0, 32'h0000_0000);
    set_arm(1'b1);
    ex("arm_b", 0, 1, 0, 0, 0);
    send(32'h0000_0077, 1'b1);
    ex("s1_inactive", 0, 1, 0, 0, 0);
    send(32'h0000_0042, 1'b1);
    ex("level_up", 0, 1, 1, 0, 0);
    send(32'h0000_0077, 1'b1);
    ex("fire_b", 1, 1, 1, 0, 0);
    set_arm(1'b0);
    ex("disarm_b", 0, 0, 1, 0, 0);
    wr(2, 1, 32'h000F_0000);
    wr(2, 0, 32'h0010_0002);
    set_arm(1'b1);
    ex("arm_c_lvl_clr", 0, 1, 0, 0, 0);
    send(32'h0000_0042, 1'b1);
    ex("count_1", 0, 1, 0, 0, 0);
    send(32'h0000_0042, 1'b0);
    ex("stall_ignored", 0, 1, 0, 0, 0);
    send(32'h0000_0042, 1'b1);
    ex("count_2", 0, 1, 0, 0, 0);
    send(32'h0000_0042, 1'b1);
    ex("fire_c", 1, 1, 0, 0, 0);
    set_arm(1'b0);
    ex("disarm_c", 0, 0, 0, 0, 0);
    wr(2, 0, 32'h0010_0000);
    wr(1, 0, 32'h0000_0055);
    ex("d_busy", 0, 0, 0, 1, 0);
    repeat (4) cyc();
    wr(0, 0, 32'h0000_FFFF);
    ex("d_err_set", 0, 0, 0, 1, 1);
    repeat (10) cyc();
    ex("d_busy_16th", 0, 0, 0, 1, 1);
    cyc();
    ex("d_busy_off", 0, 0, 0, 0, 1);
    load(0, 32'h0000_0055);
    set_arm(1'b1);
    ex("err_clr", 0, 1, 0, 0, 0);
    send(32'h1234_5642, 1'b1);
    ex("old_value", 0, 1, 0, 0, 0);
    send(32'h1234_5655, 1'b1);
    ex("mask_kept", 1, 1, 0, 0, 0);
    set_arm(1'b0);
    ex("disarm_d", 0, 0, 0, 0, 0);
    wr(3, 0, 32'h0000_0003);
    set_arm(1'b1);
    send(32'h0000_0055, 1'b1);
`ifdef TRIGGER_MULTI_DELAY_EN
    ex("dly_enter", 0, 1, 0, 0, 0);
    send(32'h0, 1'b1);
    ex("dly_1", 0, 1, 0, 0, 0);
    send(32'h0, 1'b0);
    ex("dly_stall", 0, 1, 0, 0, 0);
    send(32'h0, 1'b1);
    ex("dly_2", 0, 1, 0, 0, 0);
    send(32'h0, 1'b1);
    ex("dly_fire", 1, 1, 0, 0, 0);
    set_arm(1'b0);
    set_arm(1'b1);
    send(32'h0000_0055, 1'b1);
    send(32'h0, 1'b1);
    set_arm(1'b0);
    ex("dly_abort", 0, 0, 0, 0, 0);
    set_arm(1'b1);
    ex("rearm", 0, 1, 0, 0, 0);
    send(32'h0, 1'b1);
    ex("rearm_quiet", 0, 1, 0, 0, 0);
`else
    ex("nodly_fire", 1, 1, 0, 0, 0);
`endif
    set_arm(1'b0);
    ex("disarm_e", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trigger_multi.md
TRIGGER_MULTI -- requirements
Module: trigger_multi

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, a multiple of 4 and at least 32.
REQ-002 SHALL have parameter NS, default 4: number of trigger stages, from 1 to 8.
REQ-003 SHALL have parameter SW, default 3: stage-select width, with 2**SW >= NS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port cfg_stage, input, SW bits: target stage for configuration writes.
REQ-007 SHALL have port wr_mask, input, 1 bit: write cfg_data into the mask register of cfg_stage.
REQ-008 SHALL have port wr_value, input, 1 bit: write cfg_data into the value register of cfg_stage and start a LUT load.
REQ-009 SHALL have port wr_config, input, 1 bit: write the stage config of cfg_stage (count [15:0], level [19:16], start [20]).
REQ-010 SHALL have port wr_delay, input, 1 bit: write the stage delay from cfg_data[15:0].
REQ-011 SHALL have port cfg_data, input, DW bits: configuration write data.
REQ-012 SHALL have port arm, input, 1 bit: level-sensitive arm.
REQ-013 SHALL have port sti_tvalid, input, 1 bit: input stream valid.
REQ-014 SHALL have port sti_tready, input, 1 bit: input stream ready.
REQ-015 SHALL have port sti_tdata, input, DW bits: input stream data.
REQ-016 SHALL have port lut_busy, output, 1 bit: a LUT load is in progress.
REQ-017 SHALL have port cfg_err, output, 1 bit: sticky flag for a write dropped while busy.
REQ-018 SHALL have port capture, output, 1 bit: the block is armed or fired.
REQ-019 SHALL have port run, output, 1 bit: trigger fired; registered and sticky.
REQ-020 SHALL have port level, output, 4 bits: current trigger level.

Function
REQ-021 A transfer SHALL be sti_tvalid & sti_tready; the block SHALL evaluate data on transfers only.
REQ-022 Each stage SHALL hold DW/4 16-entry one-bit tables; entry a of nibble k SHALL equal ~|((a ^ value[4k+3:4k]) & mask[4k+3:4k]).
REQ-023 The hit for a stage SHALL be the AND of all its nibble lookups addressed by the matching sti_tdata nibbles.
REQ-024 wr_value SHALL start a 16-cycle load of the cfg_stage tables, writing address 0 through 15 one per cycle using the mask present at the time of the wr_value.
REQ-025 lut_busy SHALL be high from the cycle after wr_value through the cycle writing address 15.
REQ-026 While lut_busy is high, wr_value and wr_mask SHALL be ignored and SHALL set cfg_err; cfg_err SHALL clear on the rising edge of arm.
REQ-027 The state machine SHALL have states IDLE, ARMED, DELAY and FIRED.
REQ-028 In IDLE, arm=1 with lut_busy=0 SHALL move to ARMED and clear level and all occurrence counters.
REQ-029 arm=0 in any state SHALL return to IDLE and clear run.
REQ-030 In ARMED, a stage SHALL be active when its config level equals the level output.
REQ-031 An active stage SHALL increment its occurrence counter on each hit transfer, and SHALL match on the hit that makes the counter equal count+1; count=0 therefore means the first hit.
REQ-032 On a match by a stage with start=0, level SHALL increment by exactly 1 even if several stages match together, saturating at NS-1.
REQ-033 On a match by a stage with start=1, the block SHALL enter DELAY, or FIRED when that stage's delay is 0; start=1 SHALL take priority over level increment in the same cycle.
REQ-034 In DELAY, a down-counter loaded with the stage delay SHALL decrement once per transfer and SHALL enter FIRED when it reaches 0.
REQ-035 run SHALL be 1 exactly in FIRED; with delay 0, run SHALL assert the cycle after the matching transfer.
REQ-036 capture SHALL be registered and SHALL be 1 in ARMED, DELAY and FIRED.
REQ-037 Hit evaluation SHALL use the registered tables; a LUT load during ARMED SHALL take effect per entry as it is written.

Reset
REQ-038 rst SHALL force IDLE, with run=0, capture=0, level=0, lut_busy=0, cfg_err=0, counters=0, all masks=0, values=0 and configs=0.
REQ-039 The table contents SHALL be reset to all ones (hit always); rst asserted mid-load SHALL abort the load.

Configuration
REQ-040 With macro TRIGGER_MULTI_DELAY_EN defined, the block SHALL implement the DELAY state and the per-stage 16-bit delay registers.
REQ-041 Without TRIGGER_MULTI_DELAY_EN, wr_delay SHALL be ignored, delay SHALL read as 0, and a start match SHALL go directly to FIRED.

Verification
REQ-042 The bench SHALL cover: stage0 mask=0x000000FF, value=0x00000042, start=1, arm, then send data 0x12345642 -> run=1 one cycle later, and 0x12345643 never fires.
REQ-043 The bench SHALL cover: stage0 level0 start=0 and stage1 level1 start=1, then data matching stage1 then stage0 then stage1 -> level goes 0->1 and run asserts only on the third transfer.
REQ-044 The bench SHALL cover: count=2 on a start stage with three matching transfers -> run after the third and not before; tvalid=1 with tready=0 is not counted.
REQ-045 The bench SHALL cover: wr_value then wr_mask 5 cycles later -> lut_busy high for 16 cycles, the mask is unchanged, cfg_err=1, and cfg_err clears on the next arm rising edge.
REQ-046 The bench SHALL cover, with TRIGGER_MULTI_DELAY_EN: delay=3 on a match -> run after the 3rd subsequent transfer; arm dropped while in DELAY -> IDLE with run=0.
